alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked ALU; successor to the single-cycle datapath ALU.
- Single-cycle logic/arith ops complete with registered results.
- Iterative unsigned multiply, and optional unsigned divide, run over multiple cycles.
- Sits between the decode/register-read stage and the memory/writeback stage. Uses valid/ready on both sides so the pipeline can stall on long ops.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk        input   1      rising-edge clock
- rst        input   1      synchronous, active-high reset
- in_valid   input   1      operands/opcode valid
- in_ready   output  1      block can accept an operation
- A          input   WIDTH  operand A
- B          input   WIDTH  operand B
- ALUcontrol input   4      opcode
- out_valid  output  1      result valid
- out_ready  input   1      consumer accepts result
- result_lo  output  WIDTH  primary result / product low / quotient
- result_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops
- zero       output  1      result_lo == 0
- carry      output  1      ADD carry-out; SUB borrow (unsigned A < B); else 0
- overflow   output  1      signed overflow for ADD/SUB; else 0
- illegal    output  1      unsupported opcode, or divide by zero

Behaviour:
- Clock and reset:
  - Single clock `clk`. Reset `rst` is synchronous and active-high.
  - All outputs register-driven, except `in_ready`, which is decoded from state.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0110 SUB.
  - 0111 SLT (signed; result 1 or 0); 1100 NOR.
  - 1000 MULU; 1010 DIVU. All others are illegal.
- FSM states: IDLE, BUSY, DONE.
  - `in_ready` = 1 only in IDLE.
  - Accept occurs when `in_valid` && `in_ready`. A, B and `ALUcontrol` are captured on accept and ignored otherwise.
- Single-cycle ops: IDLE -> DONE on accept; `out_valid` = 1 on the next cycle (latency 1).
- MULU: IDLE -> BUSY. Shift-add, one bit per cycle, WIDTH iterations, then DONE.
  - Latency WIDTH+1 cycles from accept to `out_valid`.
  - {result_hi, result_lo} = 2*WIDTH-bit unsigned product.
- DIVU: IDLE -> BUSY. Restoring divide, WIDTH iterations, then DONE.
  - Latency WIDTH+1 cycles from accept to `out_valid`.
  - result_lo = quotient; result_hi = remainder.
- DIVU with B == 0: skip BUSY and go to DONE with latency 1.
  - result_lo = all ones; result_hi = A; `illegal` = 1.
- Illegal opcode: latency 1; results 0; zero = 1; `illegal` = 1.
- DONE state:
  - Results and flags are held stable while `out_valid` = 1 and `out_ready` = 0.
  - On `out_valid` && `out_ready`: go to IDLE and clear `out_valid` next cycle.
  - Results remain unchanged until the next completion.
  - Throughput: at most one op per 2 cycles; no overlap of accept and drain.
- Flag rules:
  - `zero` is evaluated on the final result_lo for every op.
  - `carry` and `overflow` apply to ADD/SUB only; all other ops force them to 0.
- Arithmetic width: ADD/SUB are computed at WIDTH+1 bits. The result is truncated to WIDTH; bit WIDTH gives carry/borrow.
- Reset behaviour:
  - Reset asserted in any state, including mid-BUSY: next state IDLE.
  - `out_valid` = 0; results, flags and the counter cleared to 0.
  - In-flight op discarded. `in_ready` = 1 after the reset cycle.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: DIVU (1010) is implemented as above.
- Undefined:
  - Divider logic is not instantiated.
  - 1010 is treated as an illegal opcode: latency 1, results 0, `illegal` = 1.
  - All other behaviour is unchanged.

Test Plan:
- ADD, A=0xFFFFFFFF, B=0x00000001 -> after 1 cycle: result_lo=0, zero=1, carry=1, overflow=0. Also A=0x7FFFFFFF, B=1 -> result_lo=0x80000000, overflow=1.
- SUB, A=5, B=7 -> result_lo=0xFFFFFFFE, carry(borrow)=1. SLT with A=0xFFFFFFFF (-1), B=1 -> result_lo=1.
- MULU, A=0xFFFFFFFF, B=0xFFFFFFFF -> out_valid exactly 33 cycles after accept; result_hi=0xFFFFFFFE, result_lo=0x00000001. in_ready=0 throughout BUSY.
- DIVU (macro on), A=100, B=7 -> after 33 cycles: result_lo=14, result_hi=2. B=0 -> after 1 cycle: result_lo=0xFFFFFFFF, result_hi=100, illegal=1. Macro off: DIVU -> illegal=1, results 0.
- Back-pressure: AND 0xF0F0F0F0 & 0x0FF00FF0 with out_ready=0 for 5 cycles -> result_lo=0x00F000F0 held with out_valid=1; no new accept. out_ready=1 -> IDLE the next cycle.
- Assert rst at cycle 10 of a MULU -> next cycle: out_valid=0, in_ready=1, all outputs 0. A following ADD 2+3 -> result_lo=5.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU: registered single-cycle logic/arith ops plus iterative shift-add multiply.
// Define ALU_SEQ_DIV_EN to add the restoring unsigned divider (opcode 1010).
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUcontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpMulu = 4'b1000;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OpDivu = 4'b1010;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] work_q, work_d;   // {acc/remainder, multiplier/quotient}
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, ill_q, ill_d;
    logic               out_valid_q, out_valid_d;
`ifdef ALU_SEQ_DIV_EN
    logic               is_div_q, is_div_d;
`endif

    // Single-cycle datapath, evaluated on the raw inputs at accept
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_carry, sc_ovf, sc_ill, sc_busy, sc_div;

    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        diff     = {1'b0, A} - {1'b0, B};
        sc_lo    = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        sc_busy  = 1'b0;
        sc_div   = 1'b0;
        case (ALUcontrol)
            OpAnd: sc_lo = A & B;
            OpOr:  sc_lo = A | B;
            OpXor: sc_lo = A ^ B;
            OpNor: sc_lo = ~(A | B);
            OpAdd: begin
                sc_lo    = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OpSub: begin
                sc_lo    = diff[WIDTH-1:0];
                sc_carry = diff[WIDTH];
                sc_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OpSlt:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OpMulu: sc_busy = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OpDivu: begin
                if (B == '0) begin
                    sc_lo  = '1;
                    sc_hi  = A;
                    sc_ill = 1'b1;
                end else begin
                    sc_busy = 1'b1;
                    sc_div  = 1'b1;
                end
            end
`endif
            default: sc_ill = 1'b1;
        endcase
    end

    // One iteration of the multi-cycle ops
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] step;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]     div_sh, div_sub;
    logic               div_ge;
`endif

    always_comb begin
        mul_add = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : '0);
        step    = {mul_add, work_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        div_sh  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_sub = div_sh - {1'b0, b_q};
        div_ge  = div_sh >= {1'b0, b_q};
        if (is_div_q) begin
            step = {(div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                    work_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        out_valid_d = out_valid_q;
`ifdef ALU_SEQ_DIV_EN
        is_div_d    = is_div_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d = {{WIDTH{1'b0}}, A};
                    b_d    = B;
                    cnt_d  = '0;
`ifdef ALU_SEQ_DIV_EN
                    is_div_d = sc_div;
`endif
                    if (sc_busy) begin
                        state_d = StBusy;
                    end else begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        lo_d        = sc_lo;
                        hi_d        = sc_hi;
                        zero_d      = (sc_lo == '0);
                        carry_d     = sc_carry;
                        ovf_d       = sc_ovf;
                        ill_d       = sc_ill;
                    end
                end
            end
            StBusy: begin
                work_d = step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LastIter) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    lo_d        = step[WIDTH-1:0];
                    hi_d        = step[2*WIDTH-1:WIDTH];
                    zero_d      = (step[WIDTH-1:0] == '0);
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    ill_d       = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            work_q      <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            is_div_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_DIV_EN
            is_div_q    <= is_div_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule
